// File: rtl/rv_decode_stage_if.sv
// Handshake bundle for the decode stage: fetch-side request and decoded-instruction response.
interface rv_decode_stage_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [ADDR_W-1:0] in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_illegal;
    logic              out_uses_rs1;
    logic              out_uses_rs2;
    logic              out_writes_rd;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_opcode,
               out_funct3, out_funct7, out_imm, out_fmt, out_illegal,
               out_uses_rs1, out_uses_rs2, out_writes_rd
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_opcode,
               out_funct3, out_funct7, out_imm, out_fmt, out_illegal,
               out_uses_rs1, out_uses_rs2, out_writes_rd
    );
endinterface

// File: rtl/rv_decode_stage.sv
// RISC-V decode stage: combinational decode into a main output register backed by a skid register,
// so in_ready comes straight from a flop.
module rv_decode_stage #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter bit RV64_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    rv_decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4, F_J = 3'd5, F_NONE = 3'd7;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN-1:0]   imm;
        logic [2:0]        fmt;
        logic              illegal;
        logic              uses_rs1;
        logic              uses_rs2;
        logic              writes_rd;
    } dec_t;

    logic [31:0] w_ins;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [2:0]  w_fmt;
    logic        w_ill;
    logic        w_shift;
    logic [63:0] w_shamt;
    logic [63:0] w_imm64;
    dec_t        w_dec;

    assign w_ins = bus.in_instr;
    assign w_f3  = w_ins[14:12];
    assign w_f7  = w_ins[31:25];

    // RV64 shifts use a 6-bit shamt; bit 25 belongs to funct7 on RV32.
    assign w_shamt = (XLEN == 64) ? {58'b0, w_ins[25:20]} : {59'b0, w_ins[24:20]};

    always_comb begin
        w_fmt   = F_NONE;
        w_ill   = 1'b0;
        w_shift = 1'b0;
        case (w_ins[6:0])
            OP_LUI, OP_AUIPC: w_fmt = F_U;
            OP_JAL:    w_fmt = F_J;
            OP_JALR:   begin w_fmt = F_I; w_ill = (w_f3 != 3'b000); end
            OP_BRANCH: begin w_fmt = F_B; w_ill = (w_f3[2:1] == 2'b01); end
            OP_LOAD: begin
                w_fmt = F_I;
                w_ill = (w_f3 == 3'b111) || (!RV64_EN && (w_f3 == 3'b011 || w_f3 == 3'b110));
            end
            OP_STORE: begin
                w_fmt = F_S;
                w_ill = w_f3[2] || (!RV64_EN && w_f3 == 3'b011);
            end
            OP_IMM:   begin w_fmt = F_I; w_shift = (w_f3[1:0] == 2'b01); end
            OP_IMM32: begin w_fmt = F_I; w_shift = (w_f3[1:0] == 2'b01); w_ill = !RV64_EN; end
            OP_OP: begin
                w_fmt = F_R;
                w_ill = !((w_f7 == 7'b0000000) ||
                          (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OP_OP32:  begin w_fmt = F_R; w_ill = !RV64_EN; end
            default:  w_ill = 1'b1;
        endcase
        if (w_ill) w_fmt = F_NONE;
    end

    // Built at 64 bits and truncated so XLEN=32 never needs a zero-width replication.
    always_comb begin
        w_imm64 = '0;
        case (w_fmt)
            F_I: w_imm64 = w_shift ? w_shamt : {{52{w_ins[31]}}, w_ins[31:20]};
            F_S: w_imm64 = {{52{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            F_B: w_imm64 = {{52{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            F_U: w_imm64 = {{32{w_ins[31]}}, w_ins[31:12], 12'b0};
            F_J: w_imm64 = {{44{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            default: w_imm64 = '0;
        endcase
    end

    always_comb begin
        w_dec           = '0;
        w_dec.pc        = bus.in_pc;
        w_dec.rs1       = w_ins[19:15];
        w_dec.rs2       = w_ins[24:20];
        w_dec.rd        = w_ins[11:7];
        w_dec.opcode    = w_ins[6:0];
        w_dec.funct3    = w_f3;
        w_dec.funct7    = w_f7;
        w_dec.imm       = w_imm64[XLEN-1:0];
        w_dec.fmt       = w_fmt;
        w_dec.illegal   = w_ill;
        w_dec.uses_rs1  = (w_fmt == F_R) || (w_fmt == F_I) || (w_fmt == F_S) || (w_fmt == F_B);
        w_dec.uses_rs2  = (w_fmt == F_R) || (w_fmt == F_S) || (w_fmt == F_B);
        w_dec.writes_rd = ((w_fmt == F_R) || (w_fmt == F_I) || (w_fmt == F_U) || (w_fmt == F_J))
                          && (w_ins[11:7] != 5'd0);
    end

    state_t r_state, w_nxt;
    logic   r_in_ready;
    dec_t   r_m, r_s;
    logic   w_acc, w_ld_new, w_ld_skid, w_ld_s2m;

    assign w_acc = bus.in_valid & r_in_ready;

    always_comb begin
        w_nxt     = r_state;
        w_ld_new  = 1'b0;
        w_ld_skid = 1'b0;
        w_ld_s2m  = 1'b0;
        if (flush) begin
            w_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_acc) begin w_nxt = FULL; w_ld_new = 1'b1; end
                FULL: begin
                    if (w_acc && bus.out_ready) w_ld_new = 1'b1;
                    else if (w_acc)             begin w_nxt = SKID; w_ld_skid = 1'b1; end
                    else if (bus.out_ready)     w_nxt = EMPTY;
                end
                SKID: if (bus.out_ready) begin w_nxt = FULL; w_ld_s2m = 1'b1; end
                default: w_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_m        <= '0;
            r_m.fmt    <= F_NONE;
            r_s        <= '0;
        end else begin
            r_state    <= w_nxt;
            r_in_ready <= (w_nxt != SKID);
            if (w_ld_new)      r_m <= w_dec;
            else if (w_ld_s2m) r_m <= r_s;
            if (w_ld_skid)     r_s <= w_dec;
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = (r_state != EMPTY);
    assign bus.out_pc        = r_m.pc;
    assign bus.out_rs1       = r_m.rs1;
    assign bus.out_rs2       = r_m.rs2;
    assign bus.out_rd        = r_m.rd;
    assign bus.out_opcode    = r_m.opcode;
    assign bus.out_funct3    = r_m.funct3;
    assign bus.out_funct7    = r_m.funct7;
    assign bus.out_imm       = r_m.imm;
    assign bus.out_fmt       = r_m.fmt;
    assign bus.out_illegal   = r_m.illegal;
    assign bus.out_uses_rs1  = r_m.uses_rs1;
    assign bus.out_uses_rs2  = r_m.uses_rs2;
    assign bus.out_writes_rd = r_m.writes_rd;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench: an RV64 instance and an RV32 (RV64_EN=0) instance share one stimulus stream.
module tb_rv_decode_stage;
    logic        clk, rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic [63:0] pc;
    int          checks = 0, errors = 0;

    rv_decode_stage_if #(.XLEN(64), .ADDR_W(64)) if0 ();
    rv_decode_stage_if #(.XLEN(32), .ADDR_W(32)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.in_instr = in_instr;  assign if1.in_instr = in_instr;
    assign if0.in_pc    = in_pc;     assign if1.in_pc    = in_pc[31:0];
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    rv_decode_stage #(.XLEN(64), .ADDR_W(64), .RV64_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0));
    rv_decode_stage #(.XLEN(32), .ADDR_W(32), .RV64_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill, u1, u2, wr;
    } exp_t;
    typedef struct { exp_t e0; exp_t e1; } pair_t;
    pair_t q[$];

    // Reference decode written from the instruction-set tables, format picked as a letter.
    function automatic exp_t ref_dec(logic [31:0] w, logic [63:0] p, int xlen, bit rv64);
        exp_t   e;
        byte    f;
        bit     ill, shift;
        longint imm;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12]; f7 = w[31:25];
        e.pc = p; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.op = w[6:0]; e.f3 = f3; e.f7 = f7;
        f = "x"; ill = 0; shift = 0; imm = 0;
        case (w[6:0])
            7'h37, 7'h17: f = "U";
            7'h6F: f = "J";
            7'h67: begin f = "I"; ill = (f3 != 0); end
            7'h63: begin f = "B"; ill = (f3 == 2 || f3 == 3); end
            7'h03: begin f = "I"; ill = (f3 == 7) || (!rv64 && (f3 == 3 || f3 == 6)); end
            7'h23: begin f = "S"; ill = (f3 >= 4) || (!rv64 && f3 == 3); end
            7'h13: begin f = "I"; shift = (f3 == 1 || f3 == 5); end
            7'h1B: begin f = "I"; shift = (f3 == 1 || f3 == 5); ill = !rv64; end
            7'h33: begin f = "R"; ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
            7'h3B: begin f = "R"; ill = !rv64; end
            default: ill = 1;
        endcase
        case (f)
            "I": if (shift) begin
                     if (xlen == 64) imm = longint'(w[25:20]);
                     else            imm = longint'(w[24:20]);
                 end else imm = $signed(w[31:20]);
            "S": imm = $signed({w[31:25], w[11:7]});
            "B": imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            "U": imm = $signed({w[31:12], 12'h000});
            "J": imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: imm = 0;
        endcase
        if (ill) f = "x";
        case (f)
            "R": e.fmt = 0; "I": e.fmt = 1; "S": e.fmt = 2;
            "B": e.fmt = 3; "U": e.fmt = 4; "J": e.fmt = 5;
            default: begin e.fmt = 7; imm = 0; end
        endcase
        e.imm = imm;
        if (xlen == 32) e.imm = {32'b0, e.imm[31:0]};
        e.ill = ill;
        e.u1  = (f == "R" || f == "I" || f == "S" || f == "B");
        e.u2  = (f == "R" || f == "S" || f == "B");
        e.wr  = (f == "R" || f == "I" || f == "U" || f == "J") && (w[11:7] != 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input logic [63:0] p,
                       input logic [4:0] rs1, rs2, rd, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [63:0] imm, input logic [2:0] fmt,
                       input logic ill, u1, u2, wr);
        chk({t, "_pc"}, p, e.pc);       chk({t, "_rs1"}, 64'(rs1), 64'(e.rs1));
        chk({t, "_rs2"}, 64'(rs2), 64'(e.rs2)); chk({t, "_rd"}, 64'(rd), 64'(e.rd));
        chk({t, "_opcode"}, 64'(op), 64'(e.op)); chk({t, "_funct3"}, 64'(f3), 64'(e.f3));
        chk({t, "_funct7"}, 64'(f7), 64'(e.f7)); chk({t, "_imm"}, imm, e.imm);
        chk({t, "_fmt"}, 64'(fmt), 64'(e.fmt)); chk({t, "_illegal"}, 64'(ill), 64'(e.ill));
        chk({t, "_uses_rs1"}, 64'(u1), 64'(e.u1)); chk({t, "_uses_rs2"}, 64'(u2), 64'(e.u2));
        chk({t, "_writes_rd"}, 64'(wr), 64'(e.wr));
    endtask

    // Monitor: check what the DUTs present, then advance the occupancy model across the next edge.
    always @(negedge clk) begin : mon
        bit rdy, vld;
        pair_t pr;
        if (!rst_n) begin
            q.delete();
        end else begin
            rdy = (q.size() < 2);
            vld = (q.size() > 0);
            chk("in_ready_64", 64'(if0.in_ready), 64'(rdy));
            chk("in_ready_32", 64'(if1.in_ready), 64'(rdy));
            chk("out_valid_64", 64'(if0.out_valid), 64'(vld));
            chk("out_valid_32", 64'(if1.out_valid), 64'(vld));
            if (vld) begin
                cmp("d64", q[0].e0, if0.out_pc, if0.out_rs1, if0.out_rs2, if0.out_rd, if0.out_opcode,
                    if0.out_funct3, if0.out_funct7, if0.out_imm, if0.out_fmt, if0.out_illegal,
                    if0.out_uses_rs1, if0.out_uses_rs2, if0.out_writes_rd);
                cmp("d32", q[0].e1, 64'(if1.out_pc), if1.out_rs1, if1.out_rs2, if1.out_rd, if1.out_opcode,
                    if1.out_funct3, if1.out_funct7, 64'(if1.out_imm), if1.out_fmt, if1.out_illegal,
                    if1.out_uses_rs1, if1.out_uses_rs2, if1.out_writes_rd);
            end
            if (flush) q.delete();
            else begin
                if (vld && out_ready) void'(q.pop_front());
                if (in_valid && rdy) begin
                    pr.e0 = ref_dec(in_instr, in_pc, 64, 1'b1);
                    pr.e1 = ref_dec(in_instr, {32'b0, in_pc[31:0]}, 32, 1'b0);
                    q.push_back(pr);
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins);
        bit ok;
        ok = 0;
        in_valid = 1'b1; in_instr = ins; in_pc = pc; pc = pc + 4;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if0.in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck low for instr %h", ins);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        if (w[6:0] == 7'h33 && $urandom_range(0, 2) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 1;
        pc = 64'h8000_0000;
        #12;
        chk("rst_out_valid", 64'(if0.out_valid), 0); chk("rst_in_ready", 64'(if0.in_ready), 1);
        chk("rst_imm", if0.out_imm, 0);              chk("rst_fmt", 64'(if0.out_fmt), 7);
        chk("rst_pc", if0.out_pc, 0);                chk("rst_fmt_32", 64'(if1.out_fmt), 7);
        #5 rst_n = 1;
        @(posedge clk); #1;

        send(32'hFFF00093);  // ADDI x1,x0,-1
        chk("addi_imm", if0.out_imm, 64'hFFFF_FFFF_FFFF_FFFF); chk("addi_fmt", 64'(if0.out_fmt), 1);
        chk("addi_rd", 64'(if0.out_rd), 1);    chk("addi_wr", 64'(if0.out_writes_rd), 1);
        chk("addi_rs2", 64'(if0.out_uses_rs2), 0); chk("addi_imm_32", 64'(if1.out_imm), 64'hFFFF_FFFF);
        send(32'h0021A423);  // SW x2,8(x3)
        chk("sw_fmt", 64'(if0.out_fmt), 2); chk("sw_imm", if0.out_imm, 8);
        chk("sw_rs1", 64'(if0.out_rs1), 3); chk("sw_rs2", 64'(if0.out_rs2), 2);
        chk("sw_wr", 64'(if0.out_writes_rd), 0); chk("sw_ill", 64'(if0.out_illegal), 0);
        send(32'hFFDFF0EF);  // JAL x1,-4
        chk("jal_fmt", 64'(if0.out_fmt), 5); chk("jal_imm", if0.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        send(32'h00000000);
        chk("zero_ill", 64'(if0.out_illegal), 1); chk("zero_fmt", 64'(if0.out_fmt), 7);
        chk("zero_flags", 64'({if0.out_uses_rs1, if0.out_uses_rs2, if0.out_writes_rd}), 0);
        send(32'h0010809B);  // ADDIW x1,x1,1
        chk("addiw_fmt_64", 64'(if0.out_fmt), 1); chk("addiw_imm_64", if0.out_imm, 1);
        chk("addiw_ill_32", 64'(if1.out_illegal), 1);
        send(32'h03F09093);  // SLLI x1,x1,63
        chk("slli_imm_64", if0.out_imm, 63);

        // Backpressure: two accepted, third held off until out_ready returns.
        @(posedge clk); #1; out_ready = 0;
        send(32'h00100113); send(32'h00200193);
        fork
            send(32'h00300213);
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", 64'(if0.in_ready), 0);
                @(posedge clk); #1; out_ready = 1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Flush while in SKID with an instruction offered on the same edge.
        out_ready = 0;
        send(32'h00400293); send(32'h00500313);
        in_valid = 1; in_instr = 32'h00600393; in_pc = pc; flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush_out_valid", 64'(if0.out_valid), 0); chk("flush_in_ready", 64'(if0.in_ready), 1);
        out_ready = 1;
        repeat (3) @(posedge clk); #1;

        for (int it = 0; it < 600; it++) begin
            @(posedge clk); #1;
            if (it == 301) rst_n = 1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = pc; pc = pc + 4;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            if (it == 300) begin
                #1 rst_n = 0;
                #1;
                chk("arst_out_valid", 64'(if0.out_valid), 0); chk("arst_in_ready", 64'(if0.in_ready), 1);
                chk("arst_imm", if0.out_imm, 0);             chk("arst_fmt", 64'(if0.out_fmt), 7);
                chk("arst_out_valid_32", 64'(if1.out_valid), 0);
            end
        end
        @(posedge clk); #1;
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
